// File: rtl/shift_n.sv
// Parameterised shift register with rotate mode, per-stage taps and a saturating fill count.
// Stage 0 holds the newest word; stage DEPTH-1 holds the oldest and drives data_out.
module shift_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_en,
    input  logic                       clear,
    input  logic                       rotate,
    input  logic [WIDTH-1:0]           data_in,
    input  logic [$clog2(DEPTH)-1:0]   tap_sel,
    output logic [WIDTH-1:0]           data_out,
    output logic [WIDTH*DEPTH-1:0]     taps,
    output logic [WIDTH-1:0]           tap_out,
    output logic [$clog2(DEPTH+1)-1:0] fill_count,
    output logic                       full
);

    localparam int unsigned SelW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [CntW-1:0]  fill_q;
    logic [CntW-1:0]  fill_d;

    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        if (clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_d[k] = '0;
            end
            fill_d = '0;
        end else if (write_en) begin
            // Rotate recirculates the oldest word; the fill count only tracks new data.
            stage_d[0] = rotate ? stage_q[DEPTH-1] : data_in;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (!rotate && (fill_q != CntW'(DEPTH))) begin
                fill_d = fill_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            fill_q <= '0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_taps
        assign taps[g*WIDTH +: WIDTH] = stage_q[g];
    end

    // Out-of-range selects (non-power-of-two DEPTH) match no stage and read as zero.
    always_comb begin
        tap_out = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_sel == SelW'(k)) begin
                tap_out = stage_q[k];
            end
        end
    end

    assign data_out   = stage_q[DEPTH-1];
    assign fill_count = fill_q;
    assign full       = (fill_q == CntW'(DEPTH));

endmodule
